// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART frame parser.
//                Holds the frame FSM state encoding, the error codes reported
//                on err_code, the UART bit timing and the default sync bytes.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    // Frame parser states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        CHK     = 3'd4
    } state_t;

    // Error codes reported on err_code
    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_CHK = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    // 50 MHz / 9600 baud
    localparam int CLKS_PER_BIT = 5208;

    // Default sync bytes
    localparam logic [7:0] HDR0_DEFAULT = 8'h55;
    localparam logic [7:0] HDR1_DEFAULT = 8'hAA;

endpackage

`default_nettype wire

// File: rtl/uart_frame_parser_if.sv
// ============================================================================
//  Module      : uart_frame_parser_if
//  Description : Signal bundle between uart_rx / command logic and the frame
//                parser.
//                  pi_data/pi_flag   byte stream from uart_rx
//                  rd_addr/rd_data   payload buffer read port (1-cycle latency)
//                  pkt_valid/pkt_len good-frame report
//                  err_pulse/err_code frame rejection report
//                  busy              parser is inside a frame
//                  good_cnt/err_cnt  statistics counters
//                modport slave  : the parser
//                modport master : the environment driving it
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_frame_parser_if #(
    parameter int MAX_LEN = 16
);
    localparam int ADDR_W = $clog2(MAX_LEN);
    localparam int LEN_W  = ADDR_W + 1;

    logic [7:0]        pi_data;
    logic              pi_flag;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              pkt_valid;
    logic [LEN_W-1:0]  pkt_len;
    logic              busy;
    logic              err_pulse;
    logic [1:0]        err_code;
    logic [15:0]       good_cnt;
    logic [15:0]       err_cnt;

    modport slave (
        input  pi_data, pi_flag, rd_addr,
        output rd_data, pkt_valid, pkt_len, busy, err_pulse, err_code,
               good_cnt, err_cnt
    );

    modport master (
        output pi_data, pi_flag, rd_addr,
        input  rd_data, pkt_valid, pkt_len, busy, err_pulse, err_code,
               good_cnt, err_cnt
    );

endinterface

`default_nettype wire

// File: rtl/frame_timeout_timer.sv
// ============================================================================
//  Module      : frame_timeout_timer
//  Description : Inter-byte watchdog. Counts while enabled, restarts on
//                clear, and pulses o_expire in the cycle the count reaches
//                TIMEOUT_CLKS-1 without a clear.
//                  clk, rst  clock / synchronous active-high reset
//                  i_clear   restart the count (takes priority)
//                  i_enable  count this cycle
//                  o_expire  combinational one-cycle expiry indication
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_timeout_timer #(
    parameter int TIMEOUT_CLKS = 104160
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT_CLKS - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= (r_count == c_last) ? '0 : r_count + 1'b1;
        end
    end

    // A byte arriving on the expiry cycle clears the timer and wins
    assign o_expire = i_enable && !i_clear && (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/uart_frame_parser.sv
// ============================================================================
//  Module      : uart_frame_parser
//  Description : Assembles the uart_rx byte stream into frames
//                  HDR0, HDR1, LEN, LEN payload bytes, CHK
//                where CHK is the 8-bit wrapping sum of LEN and the payload.
//                Good frames store the payload in an in-place buffer and
//                pulse pkt_valid; bad length, bad checksum or an inter-byte
//                stall pulse err_pulse with err_code.
//                  sys_clk, sys_rst  clock / synchronous active-high reset
//                  bus (slave)       byte input, buffer read port, status
//                Build option: define UART_PARSER_STATS_EN to implement the
//                saturating good_cnt/err_cnt counters; otherwise they are 0.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 104160,
    parameter logic [7:0] HDR0         = HDR0_DEFAULT,
    parameter logic [7:0] HDR1         = HDR1_DEFAULT
) (
    input  wire logic          sys_clk,
    input  wire logic          sys_rst,
    uart_frame_parser_if.slave bus
);

    localparam int ADDR_W = $clog2(MAX_LEN);
    localparam int LEN_W  = ADDR_W + 1;
    localparam logic [7:0] c_max_len = 8'(MAX_LEN);

    state_t r_state, w_state_nxt;

    logic [7:0]        r_buf [MAX_LEN];
    logic [7:0]        r_len;
    logic [7:0]        r_sum;
    logic [ADDR_W-1:0] r_idx;
    logic [7:0]        r_rd_data;
    logic              r_pkt_valid;
    logic [LEN_W-1:0]  r_pkt_len;
    logic              r_err_pulse;
    logic [1:0]        r_err_code;

    logic       w_buf_we;
    logic       w_len_ld;
    logic       w_good;
    logic       w_err;
    logic [1:0] w_err_code;
    logic       w_expire;
    logic       w_in_idle;

    assign w_in_idle = (r_state == IDLE);

    frame_timeout_timer #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timer (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .i_clear  (bus.pi_flag || w_in_idle),
        .i_enable (!w_in_idle),
        .o_expire (w_expire)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_buf_we    = 1'b0;
        w_len_ld    = 1'b0;
        w_good      = 1'b0;
        w_err       = 1'b0;
        w_err_code  = ERR_LEN;
        // Expiry can only fire on a cycle without pi_flag
        if (w_expire) begin
            w_state_nxt = IDLE;
            w_err       = 1'b1;
            w_err_code  = ERR_TMO;
        end else if (bus.pi_flag) begin
            case (r_state)
                IDLE: begin
                    if (bus.pi_data == HDR0) w_state_nxt = SYNC;
                end
                SYNC: begin
                    // A repeated HDR0 is treated as a fresh frame start
                    if (bus.pi_data == HDR1)      w_state_nxt = LEN;
                    else if (bus.pi_data == HDR0) w_state_nxt = SYNC;
                    else                          w_state_nxt = IDLE;
                end
                LEN: begin
                    if ((bus.pi_data != 8'd0) && (bus.pi_data <= c_max_len)) begin
                        w_len_ld    = 1'b1;
                        w_state_nxt = PAYLOAD;
                    end else begin
                        w_err       = 1'b1;
                        w_err_code  = ERR_LEN;
                        w_state_nxt = IDLE;
                    end
                end
                PAYLOAD: begin
                    w_buf_we = 1'b1;
                    if (8'(r_idx) == r_len - 8'd1) w_state_nxt = CHK;
                end
                CHK: begin
                    if (bus.pi_data == r_sum) begin
                        w_good = 1'b1;
                    end else begin
                        w_err      = 1'b1;
                        w_err_code = ERR_CHK;
                    end
                    w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_len       <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_rd_data   <= '0;
            r_pkt_valid <= 1'b0;
            r_pkt_len   <= '0;
            r_err_pulse <= 1'b0;
            r_err_code  <= '0;
        end else begin
            r_pkt_valid <= w_good;
            r_err_pulse <= w_err;
            r_rd_data   <= r_buf[bus.rd_addr];
            if (w_good) r_pkt_len  <= LEN_W'(r_len);
            if (w_err)  r_err_code <= w_err_code;
            if (w_len_ld) begin
                r_len <= bus.pi_data;
                r_sum <= bus.pi_data;
                r_idx <= '0;
            end
            if (w_buf_we) begin
                r_sum <= r_sum + bus.pi_data;
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Payload storage is not reset; contents are only meaningful after a
    // good frame and until the next accepted LEN byte.
    always_ff @(posedge sys_clk) begin
        if (w_buf_we) r_buf[r_idx] <= bus.pi_data;
    end

    assign bus.rd_data   = r_rd_data;
    assign bus.pkt_valid = r_pkt_valid;
    assign bus.pkt_len   = r_pkt_len;
    assign bus.err_pulse = r_err_pulse;
    assign bus.err_code  = r_err_code;
    assign bus.busy      = !w_in_idle;

`ifdef UART_PARSER_STATS_EN
    logic [15:0] r_good_cnt;
    logic [15:0] r_err_cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_good_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (r_pkt_valid && (r_good_cnt != 16'hFFFF)) r_good_cnt <= r_good_cnt + 16'd1;
            if (r_err_pulse && (r_err_cnt  != 16'hFFFF)) r_err_cnt  <= r_err_cnt  + 16'd1;
        end
    end

    assign bus.good_cnt = r_good_cnt;
    assign bus.err_cnt  = r_err_cnt;
`else
    assign bus.good_cnt = '0;
    assign bus.err_cnt  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
// ============================================================================
//  Module      : tb_uart_frame_parser
//  Description : Self-checking bench for uart_frame_parser. Frames are built
//                from directed and random contents; the expected outcome of
//                each frame is derived from its bytes by a frame-level model
//                (find header, read LEN, sum payload, compare CHK).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_frame_parser;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 200;

    typedef logic [7:0] bq_t [$];

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    uart_frame_parser_if #(.MAX_LEN(MAX_LEN)) bus ();

    uart_frame_parser #(
        .MAX_LEN      (MAX_LEN),
        .TIMEOUT_CLKS (TMO),
        .HDR0         (8'h55),
        .HDR1         (8'hAA)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Pulse monitor
    int n_good_ev = 0;
    int n_err_ev  = 0;
    int n_both    = 0;
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (bus.pkt_valid) n_good_ev++;
            if (bus.err_pulse) n_err_ev++;
            if (bus.pkt_valid && bus.err_pulse) n_both++;
        end
    end

    // Expected persistent state
    int exp_good_cnt = 0;
    int exp_err_cnt  = 0;
    int exp_pkt_len  = 0;
    int exp_err_code = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge sys_clk); #1;
        bus.pi_data = b;
        bus.pi_flag = 1'b1;
        @(posedge sys_clk); #1;
        bus.pi_flag = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        exp_good_cnt = 0;
        exp_err_cnt  = 0;
        exp_pkt_len  = 0;
        exp_err_code = 0;
    endtask

    task automatic check_stats(input string tag);
`ifdef UART_PARSER_STATS_EN
        check_eq({tag, ".good_cnt"}, 32'(bus.good_cnt), exp_good_cnt);
        check_eq({tag, ".err_cnt"},  32'(bus.err_cnt),  exp_err_cnt);
`else
        check_eq({tag, ".good_cnt"}, 32'(bus.good_cnt), 0);
        check_eq({tag, ".err_cnt"},  32'(bus.err_cnt),  0);
`endif
    endtask

    // Frame-level model plus stimulus: the last byte of q must be the
    // deciding byte of the frame.
    task automatic run_frame(input string tag, input bq_t q, input bit rand_gaps);
        int hi, len, sum, g0, e0;
        bit exp_good, exp_err;
        int code;
        hi = -1;
        for (int i = 0; i + 1 < q.size(); i++) begin
            if (q[i] == 8'h55 && q[i+1] == 8'hAA) begin
                hi = i;
                break;
            end
        end
        len = int'(q[hi+2]);
        exp_good = 1'b0;
        exp_err  = 1'b0;
        code     = 0;
        if (len == 0 || len > MAX_LEN) begin
            exp_err = 1'b1;
            code    = 1;
        end else begin
            sum = len;
            for (int i = 0; i < len; i++) sum += int'(q[hi+3+i]);
            if ((sum % 256) == int'(q[hi+3+len])) exp_good = 1'b1;
            else begin
                exp_err = 1'b1;
                code    = 2;
            end
        end

        g0 = n_good_ev;
        e0 = n_err_ev;
        foreach (q[i]) begin
            send_byte(q[i]);
            if (rand_gaps && i != q.size() - 1) repeat ($urandom_range(0, 4)) @(posedge sys_clk);
        end
        check_eq({tag, ".pkt_valid"}, 32'(bus.pkt_valid), 32'(exp_good));
        check_eq({tag, ".err_pulse"}, 32'(bus.err_pulse), 32'(exp_err));

        if (exp_good) begin
            exp_good_cnt++;
            exp_pkt_len = len;
            for (int i = 0; i < len; i++) begin
                bus.rd_addr = 4'(i);
                @(posedge sys_clk); #1;
                check_eq($sformatf("%s.rd%0d", tag, i), 32'(bus.rd_data), 32'(q[hi+3+i]));
            end
        end else begin
            exp_err_cnt++;
            exp_err_code = code;
        end
        repeat (2) @(posedge sys_clk);
        #1;
        check_eq({tag, ".pkt_len"},  32'(bus.pkt_len),  exp_pkt_len);
        check_eq({tag, ".err_code"}, 32'(bus.err_code), exp_err_code);
        check_eq({tag, ".busy"},     32'(bus.busy),     0);
        check_eq({tag, ".n_events"}, (n_good_ev - g0) + (n_err_ev - e0), 1);
    endtask

    // Random good (or corrupted-checksum) frame of given length
    function automatic bq_t make_frame(input int len, input bit corrupt);
        bq_t q;
        int sum;
        logic [7:0] b;
        q = {8'h55, 8'hAA, 8'(len)};
        sum = len;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            sum += int'(b);
        end
        b = 8'(sum);
        if (corrupt) b = b ^ 8'(1 + $urandom_range(0, 254));
        q.push_back(b);
        return q;
    endfunction

    initial begin
        bq_t q;
        int kind, g0, e0;

        bus.pi_data = 8'h00;
        bus.pi_flag = 1'b0;
        bus.rd_addr = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;

        check_eq("rst.pkt_valid", 32'(bus.pkt_valid), 0);
        check_eq("rst.pkt_len",   32'(bus.pkt_len),   0);
        check_eq("rst.busy",      32'(bus.busy),      0);
        check_eq("rst.err_pulse", 32'(bus.err_pulse), 0);
        check_eq("rst.err_code",  32'(bus.err_code),  0);
        check_eq("rst.rd_data",   32'(bus.rd_data),   0);
        check_stats("rst");

        run_frame("good3",  '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, 1'b0);
        run_frame("chkerr", '{8'h55, 8'hAA, 8'h02, 8'h10, 8'h20, 8'h00}, 1'b0);
        run_frame("len0",   '{8'h55, 8'hAA, 8'h00}, 1'b0);
        run_frame("len17",  '{8'h55, 8'hAA, 8'h11}, 1'b0);
        run_frame("resync", '{8'h12, 8'h55, 8'h55, 8'hAA, 8'h01, 8'hFF, 8'h00}, 1'b0);
        run_frame("lenmax", make_frame(MAX_LEN, 1'b0), 1'b1);

        // Timeout: expiry exactly TMO cycles after the last byte's flag
        g0 = n_good_ev;
        e0 = n_err_ev;
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h02);
        send_byte(8'h41);
        repeat (TMO - 1) @(posedge sys_clk);
        #1;
        check_eq("tmo.early", 32'(bus.err_pulse) + 32'(n_err_ev - e0), 0);
        check_eq("tmo.busy",  32'(bus.busy), 1);
        @(posedge sys_clk); #1;
        check_eq("tmo.err_pulse", 32'(bus.err_pulse), 1);
        check_eq("tmo.err_code",  32'(bus.err_code),  3);
        exp_err_cnt++;
        exp_err_code = 3;
        @(posedge sys_clk); #1;
        check_eq("tmo.busy_after", 32'(bus.busy), 0);
        check_eq("tmo.no_good", n_good_ev - g0, 0);
        run_frame("post_tmo", make_frame(2, 1'b0), 1'b1);
        check_stats("mid");

        // Reset during PAYLOAD aborts silently
        e0 = n_err_ev;
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h04);
        send_byte(8'h01);
        check_eq("rstmid.busy_before", 32'(bus.busy), 1);
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        exp_good_cnt = 0;
        exp_err_cnt  = 0;
        exp_pkt_len  = 0;
        exp_err_code = 0;
        check_eq("rstmid.busy",     32'(bus.busy),      0);
        check_eq("rstmid.err",      32'(bus.err_pulse), 0);
        check_eq("rstmid.pkt_len",  32'(bus.pkt_len),   0);
        repeat (3) @(posedge sys_clk);
        #1;
        check_eq("rstmid.no_err", n_err_ev - e0, 0);

        // Stats: two good, one bad
        run_frame("st_g1", make_frame(1, 1'b0), 1'b1);
        run_frame("st_b1", make_frame(5, 1'b1), 1'b1);
        run_frame("st_g2", make_frame(7, 1'b0), 1'b1);
        check_stats("stats");

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 4));
            case (kind)
                0: q = make_frame(int'($urandom_range(1, MAX_LEN)), 1'b0);
                1: q = make_frame(int'($urandom_range(1, MAX_LEN)), 1'b1);
                2: q = '{8'h55, 8'hAA, 8'h00};
                3: q = '{8'h55, 8'hAA, 8'($urandom_range(MAX_LEN + 1, 255))};
                default: begin
                    q = make_frame(int'($urandom_range(1, MAX_LEN)), 1'b0);
                    q.push_front(8'h55);
                    q.push_front(8'($urandom_range(0, 8'h54)));
                end
            endcase
            run_frame($sformatf("rnd%0d", n), q, 1'b1);
        end
        check_stats("final");
        check_eq("no_overlap", n_both, 0);

        do_reset();
        @(posedge sys_clk); #1;
        check_stats("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
